uart_sram_loader_param: RTL
===========================

UART_SRAM_LOADER_PARAM -- requirements
Module: uart_sram_loader_param

Interface
REQ-001 Parameter DATA_WIDTH, default 16, meaning SRAM word width; SHALL be a multiple of 8 in the range 8..32; BPW = DATA_WIDTH/8 bytes per word.
REQ-002 Parameter ADDR_WIDTH, default 18, meaning SRAM address width.
REQ-003 Parameter HEADER_LF, default 0, meaning count of line feeds (8'h0A) to strip before payload; range 0..7, where 0 disables stripping.
REQ-004 Parameter LITTLE_ENDIAN, default 0, meaning byte order: 0 puts the first byte in the MSB, 1 puts the first byte in the LSB.
REQ-005 Clock  input  1  rising-edge system clock; single clock domain.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 Initialize  input  1  synchronous soft clear; priority below Reset.
REQ-008 Enable  input  1  start request, sampled only in IDLE.
REQ-009 Start_address  input  ADDR_WIDTH  first write address, sampled on start.
REQ-010 Word_limit  input  ADDR_WIDTH  number of words to write; 0 = unlimited (stop at all-ones address); sampled on start.
REQ-011 Rx_data  input  8  byte from the UART receive controller.
REQ-012 Rx_empty  input  1  receiver buffer empty flag.
REQ-013 Rx_enable  output  1  receiver enable.
REQ-014 Rx_unload  output  1  receiver unload request.
REQ-015 SRAM_address  output  ADDR_WIDTH  write address.
REQ-016 SRAM_write_data  output  DATA_WIDTH  assembled word.
REQ-017 SRAM_we_n  output  1  active-low write enable.
REQ-018 Word_count  output  ADDR_WIDTH  words written since start.
REQ-019 Checksum  output  16  modulo-2^16 sum of all payload bytes, zero-extended.
REQ-020 Done  output  1  high while in DONE.

Function
REQ-021 States SHALL be IDLE, HDR_WAIT, HDR_ACK, BYTE_WAIT, BYTE_ACK, WRITE and DONE.
REQ-022 In IDLE with Enable=1, the block SHALL set Rx_enable=1, load SRAM_address=Start_address, clear Word_count, Checksum and the byte index, and go to HDR_WAIT if HEADER_LF>0, else to BYTE_WAIT.
REQ-023 In HDR_WAIT with Rx_empty=0, the block SHALL set Rx_unload=1, increment the LF counter if Rx_data=8'h0A, and go to HDR_ACK; header bytes SHALL NOT affect Checksum or SRAM.
REQ-024 In HDR_ACK with Rx_empty=1, the block SHALL set Rx_unload=0 and go to BYTE_WAIT if the LF count equals HEADER_LF, else to HDR_WAIT.
REQ-025 In BYTE_WAIT with Rx_empty=0, the block SHALL set Rx_unload=1, write Rx_data into the byte lane selected by the byte index and LITTLE_ENDIAN, add Rx_data to Checksum, and go to BYTE_ACK.
REQ-026 In BYTE_ACK with Rx_empty=1, the block SHALL set Rx_unload=0; if byte index = BPW-1, it SHALL set SRAM_we_n=0, reset the index and go to WRITE; otherwise it SHALL increment the index and go to BYTE_WAIT.
REQ-027 While a wait state's condition is false, all outputs SHALL hold.
REQ-028 In WRITE, the block SHALL set SRAM_we_n=1 and Word_count+=1, so SRAM_we_n is low for exactly one cycle per word with address and data stable.
REQ-029 In WRITE, if Word_limit≠0 and Word_count+1=Word_limit, or SRAM_address is all ones, the block SHALL set Rx_enable=0 and go to DONE; otherwise it SHALL set SRAM_address+=1 and go to BYTE_WAIT.
REQ-030 SRAM_address SHALL never wrap past all ones; if Start_address is all ones, exactly one word SHALL be written.
REQ-031 DONE SHALL hold Done=1 and ignore Enable and Rx_empty until Initialize or Reset.
REQ-032 Initialize=1 in any state SHALL apply the reset values of REQ-033 in the next cycle, including mid-word; partial words SHALL be discarded with no write.

Reset
REQ-033 On Reset=1, the block SHALL drive state=IDLE, Rx_enable=0, Rx_unload=0, SRAM_we_n=1, and zero SRAM_write_data, SRAM_address, Word_count, Checksum, Done and all internal counters.
REQ-034 Reset SHALL take priority over Initialize, Enable and all handshakes.

Verification
REQ-035 Defaults, Start_address=0, Word_limit=2, bytes 12,34,56,78 -> writes 0x1234@0 then 0x5678@1, each SRAM_we_n pulse one cycle, Done=1, Word_count=2, Checksum=0x0114.
REQ-036 LITTLE_ENDIAN=1, DATA_WIDTH=32, bytes 01,02,03,04 -> single write of 0x04030201.
REQ-037 HEADER_LF=3, stream "P5\n4 4\n255\n" then AA,BB -> header bytes are not written, first write is 0xAABB, and Checksum=0x0165.
REQ-038 Start_address=0x3FFFE, Word_limit=0, 6 bytes -> writes at 0x3FFFE and 0x3FFFF only, then DONE, Rx_enable=0, and the 5th and 6th bytes are never unloaded.
REQ-039 Initialize asserted after the first byte of a word -> no SRAM write, next state IDLE, all outputs at reset values; a subsequent Enable restarts cleanly.
REQ-040 Rx_empty held high for 100 cycles in BYTE_WAIT -> outputs stable, Rx_unload=0, no write.

Source files
------------

// File: rtl/uart_sram_loader_param.sv
// Streams UART bytes (after an optional LF-terminated header) into SRAM words, one we_n pulse per word.
// Four cycles per byte minimum plus one write cycle per word; stalls indefinitely on Rx_empty.
module uart_sram_loader_param #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 18,
    parameter int HEADER_LF     = 0,
    parameter int LITTLE_ENDIAN = 0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Initialize,
    input  logic                  Enable,
    input  logic [ADDR_WIDTH-1:0] Start_address,
    input  logic [ADDR_WIDTH-1:0] Word_limit,
    input  logic [7:0]            Rx_data,
    input  logic                  Rx_empty,
    output logic                  Rx_enable,
    output logic                  Rx_unload,
    output logic [ADDR_WIDTH-1:0] SRAM_address,
    output logic [DATA_WIDTH-1:0] SRAM_write_data,
    output logic                  SRAM_we_n,
    output logic [ADDR_WIDTH-1:0] Word_count,
    output logic [15:0]           Checksum,
    output logic                  Done
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam logic [1:0] LAST_IDX = 2'(BPW - 1);
    localparam logic [2:0] HDR_LFS = 3'(HEADER_LF);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    typedef enum logic [2:0] {
        IDLE, HDR_WAIT, HDR_ACK, BYTE_WAIT, BYTE_ACK, WRITE, DONE
    } state_t;

    state_t                state;
    logic [1:0]            byte_idx;
    logic [2:0]            lf_count;
    logic [ADDR_WIDTH-1:0] word_limit_q;
    logic [1:0]            lane;
    logic [4:0]            lane_lsb;
    logic [ADDR_WIDTH-1:0] next_count;

    // Big-endian fills from the top lane down so the first byte lands in the MSB.
    always_comb begin
        lane       = (LITTLE_ENDIAN != 0) ? byte_idx : (LAST_IDX - byte_idx);
        lane_lsb   = {lane, 3'b000};
        next_count = Word_count + 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (Reset || Initialize) begin
            state           <= IDLE;
            Rx_enable       <= 1'b0;
            Rx_unload       <= 1'b0;
            SRAM_we_n       <= 1'b1;
            SRAM_write_data <= '0;
            SRAM_address    <= '0;
            Word_count      <= '0;
            Checksum        <= '0;
            Done            <= 1'b0;
            byte_idx        <= '0;
            lf_count        <= '0;
            word_limit_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Enable) begin
                        Rx_enable    <= 1'b1;
                        SRAM_address <= Start_address;
                        word_limit_q <= Word_limit;
                        Word_count   <= '0;
                        Checksum     <= '0;
                        byte_idx     <= '0;
                        lf_count     <= '0;
                        state        <= (HEADER_LF > 0) ? HDR_WAIT : BYTE_WAIT;
                    end
                end
                HDR_WAIT: begin
                    if (!Rx_empty) begin
                        Rx_unload <= 1'b1;
                        if (Rx_data == 8'h0A)
                            lf_count <= lf_count + 1'b1;
                        state <= HDR_ACK;
                    end
                end
                HDR_ACK: begin
                    if (Rx_empty) begin
                        Rx_unload <= 1'b0;
                        state     <= (lf_count == HDR_LFS) ? BYTE_WAIT : HDR_WAIT;
                    end
                end
                BYTE_WAIT: begin
                    if (!Rx_empty) begin
                        Rx_unload                         <= 1'b1;
                        SRAM_write_data[lane_lsb +: 8]    <= Rx_data;
                        Checksum                          <= Checksum + 16'(Rx_data);
                        state                             <= BYTE_ACK;
                    end
                end
                BYTE_ACK: begin
                    if (Rx_empty) begin
                        Rx_unload <= 1'b0;
                        if (byte_idx == LAST_IDX) begin
                            SRAM_we_n <= 1'b0;
                            byte_idx  <= '0;
                            state     <= WRITE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= BYTE_WAIT;
                        end
                    end
                end
                WRITE: begin
                    SRAM_we_n  <= 1'b1;
                    Word_count <= next_count;
                    // Stop at the limit or the top address; the address never wraps.
                    if ((word_limit_q != '0 && next_count == word_limit_q) ||
                        SRAM_address == ADDR_MAX) begin
                        Rx_enable <= 1'b0;
                        Done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        SRAM_address <= SRAM_address + 1'b1;
                        state        <= BYTE_WAIT;
                    end
                end
                DONE: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
